mult_seq: RTL and testbench
===========================

// Module: mult_seq
// PURPOSE
//   Sequential shift-add unsigned multiplier that produces the 8-bit radicand for sqrt.
//   Computes y = a * b over WIDTH clock cycles, one multiplier bit per cycle.
//   Uses the same pulse handshake as sqrt, so y_out/y_ready wire straight to x_in/x_ready.
// PARAMETERS
//   WIDTH  4  operand width in bits; the product is 2*WIDTH bits wide (8 at default)
// PORTS
//   clk      in   1          system clock; all state changes on the rising edge
//   rst      in   1          synchronous, active-high reset
//   a_in     in   WIDTH      multiplicand, sampled only on an accepted start
//   b_in     in   WIDTH      multiplier, sampled only on an accepted start
//   x_ready  in   1          start request; accepted only when busy==0
//   y_out    out  2*WIDTH    product; holds the last result until the next completion
//   y_ready  out  1          one-cycle pulse: y_out is valid and new this cycle
//   busy     out  1          high while a multiplication is in progress
// BEHAVIOUR
//   - One clock domain. Reset is synchronous and active-high (rst sampled at the clk rising edge).
//   - Reset values: y_out=0, y_ready=0, busy=0, state=IDLE, all internal registers 0.
//   - rst has priority over every other input. Reset during COMPUTE aborts the operation:
//     no y_ready pulse is produced, and y_out is forced to 0.
//   - States: IDLE, COMPUTE.
//   - IDLE, edge with x_ready=1 (edge E0):
//     latch acc=0, mcand={WIDTH'b0,a_in}, mplier=b_in, cnt=WIDTH;
//     busy<=1; go to COMPUTE.
//   - IDLE, edge with x_ready=0: no change; y_ready<=0.
//   - COMPUTE, each edge:
//     if mplier[0] then acc+=mcand;
//     mcand<<=1; mplier>>=1; cnt-=1.
//   - COMPUTE, edge where cnt==1 (edge E_WIDTH):
//     y_out<=final acc; y_ready<=1; busy<=0; go to IDLE.
//   - Latency: y_ready is high in the cycle following edge E_WIDTH, i.e. WIDTH clocks after the
//     accepting edge. The pulse lasts exactly one cycle.
//   - y_ready is 0 on every other edge. y_out changes only at completion or on reset.
//   - x_ready while busy==1 is ignored: no queuing, operands are not resampled, the
//     in-flight result is unaffected.
//   - Back-to-back operation: busy is 0 during the y_ready cycle, so x_ready in that cycle is
//     accepted. Sustained throughput is one result per WIDTH+1 cycles.
//   - Arithmetic: unsigned. The 2*WIDTH accumulator cannot overflow
//     (max (2^W-1)^2 < 2^(2W)).
//   - Operands are captured at acceptance; a_in/b_in may change freely afterwards.
//   - A level-held x_ready re-triggers at every completion; callers drive it as a
//     one-cycle pulse.
// TESTING
//   1. rst=1 for 2 cycles -> y_out=0, y_ready=0, busy=0.
//      Idle with x_ready=0 for 10 cycles -> no y_ready pulse.
//   2. a=13, b=15, x_ready pulse -> busy for 4 cycles; y_ready pulses once 4 clocks after
//      acceptance with y_out=195 (0xC3). Chained into sqrt, this yields y=13.
//   3. Corners: a=15,b=15 -> 225; a=0,b=9 -> 0; a=7,b=0 -> 0; a=1,b=1 -> 1.
//      Each result checked at the y_ready pulse.
//   4. a=3,b=5 accepted; x_ready pulsed again 2 cycles later with a=9,b=9
//      -> single result 15, no second pulse.
//   5. a=2,b=3 accepted; x_ready asserted with a=4,b=4 in the y_ready cycle
//      -> 6, then 16 exactly 5 cycles later.
//   6. a=11,b=11 accepted; rst pulsed 2 cycles later -> no y_ready, y_out=0, busy=0.
//      Next start with a=5,b=5 -> 25.

Source files
------------

// File: rtl/mult_seq.sv
// ============================================================================
// Module   : mult_seq
// Brief    : Sequential shift-add unsigned multiplier, one multiplier bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 x_ready,
    output logic [2*WIDTH-1:0]   y_out,
    output logic                 y_ready,
    output logic                 busy
);

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [2*WIDTH-1:0]   r_acc, w_acc_nxt;
    logic [2*WIDTH-1:0]   r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0]     r_mplier, w_mplier_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [2*WIDTH-1:0]   r_y_out, w_y_out_nxt;
    logic                 r_y_ready, w_y_ready_nxt;
    logic                 r_busy, w_busy_nxt;
    logic [2*WIDTH-1:0]   w_sum;

    // Partial product for this cycle; the final step's sum is the result.
    assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_y_out   <= '0;
            r_y_ready <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplier  <= w_mplier_nxt;
            r_cnt     <= w_cnt_nxt;
            r_y_out   <= w_y_out_nxt;
            r_y_ready <= w_y_ready_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_mcand_nxt   = r_mcand;
        w_mplier_nxt  = r_mplier;
        w_cnt_nxt     = r_cnt;
        w_y_out_nxt   = r_y_out;
        w_y_ready_nxt = 1'b0;
        w_busy_nxt    = r_busy;

        case (r_state)
            IDLE: begin
                if (x_ready) begin
                    w_acc_nxt    = '0;
                    w_mcand_nxt  = {{WIDTH{1'b0}}, a_in};
                    w_mplier_nxt = b_in;
                    w_cnt_nxt    = c_cnt_init;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = COMPUTE;
                end
            end
            COMPUTE: begin
                // x_ready is deliberately not looked at here: no queuing while busy.
                w_acc_nxt    = w_sum;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt - c_cnt_last;
                if (r_cnt == c_cnt_last) begin
                    w_y_out_nxt   = w_sum;
                    w_y_ready_nxt = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign y_out   = r_y_out;
    assign y_ready = r_y_ready;
    assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq.sv
// ============================================================================
// Module   : tb_mult_seq
// Brief    : Self-checking bench for mult_seq: vector table, scoreboard, corner sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_seq;

    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [WIDTH-1:0]   a_in = '0;
    logic [WIDTH-1:0]   b_in = '0;
    logic               x_ready = 1'b0;
    logic [2*WIDTH-1:0] y_out;
    logic               y_ready;
    logic               busy;

    mult_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_in    (a_in),
        .b_in    (b_in),
        .x_ready (x_ready),
        .y_out   (y_out),
        .y_ready (y_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] exp;
    } vec_t;

    typedef struct {
        logic [2*WIDTH-1:0] exp;
        int                 acc_cyc;
    } sb_t;

    sb_t  sb[$];
    int   pulse_log[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every y_ready pulse must match the oldest accepted operation.
    always @(negedge clk) begin
        if (y_ready === 1'b1) begin
            pulse_log.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("product", int'(y_out), int'(e.exp));
                check("latency", cyc - e.acc_cyc, WIDTH);
            end
        end
    end

    // Drives a one-cycle start pulse; returns at the accepting edge + 1.
    task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit expect_it, input logic [2*WIDTH-1:0] exp);
        a_in    = a;
        b_in    = b;
        x_ready = 1'b1;
        @(posedge clk);
        #1;
        x_ready = 1'b0;
        if (expect_it) sb.push_back('{exp: exp, acc_cyc: cyc});
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("done_timeout", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int               n0;
        logic [WIDTH-1:0] ra, rb;

        vecs[0] = '{a: 4'd15, b: 4'd15, exp: 8'd225};
        vecs[1] = '{a: 4'd0,  b: 4'd9,  exp: 8'd0};
        vecs[2] = '{a: 4'd7,  b: 4'd0,  exp: 8'd0};
        vecs[3] = '{a: 4'd1,  b: 4'd1,  exp: 8'd1};
        vecs[4] = '{a: 4'd10, b: 4'd12, exp: 8'd120};
        vecs[5] = '{a: 4'd15, b: 4'd1,  exp: 8'd15};
        vecs[6] = '{a: 4'd1,  b: 4'd15, exp: 8'd15};

        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_y_out", int'(y_out), 0);
        check("reset_y_ready", int'(y_ready), 0);
        check("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        n0 = pulse_log.size();
        repeat (10) @(posedge clk);
        #1;
        check("idle_no_pulse", pulse_log.size(), n0);

        // 13 * 15 with busy profile and single-cycle pulse
        start(4'd13, 4'd15, 1'b1, 8'd195);
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            check("busy_during_compute", int'(busy), 1);
        end
        @(negedge clk);
        check("busy_at_done", int'(busy), 0);
        check("y_ready_at_done", int'(y_ready), 1);
        @(negedge clk);
        check("pulse_one_cycle", int'(y_ready), 0);
        check("y_out_holds", int'(y_out), 195);
        @(posedge clk);
        #1;
        wait_done();

        // Vector table
        foreach (vecs[i]) begin
            start(vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp);
            wait_done();
        end

        // Random operands against the bench's own product
        for (int i = 0; i < 8; i++) begin
            ra = WIDTH'($urandom_range(0, 15));
            rb = WIDTH'($urandom_range(0, 15));
            start(ra, rb, 1'b1, (2*WIDTH)'(ra) * (2*WIDTH)'(rb));
            wait_done();
        end

        // Start while busy is ignored
        n0 = pulse_log.size();
        start(4'd3, 4'd5, 1'b1, 8'd15);
        repeat (2) @(posedge clk);
        #1;
        start(4'd9, 4'd9, 1'b0, 8'd0);
        wait_done();
        repeat (10) @(posedge clk);
        #1;
        check("ignored_start_pulses", pulse_log.size() - n0, 1);
        check("ignored_start_y_out", int'(y_out), 15);

        // Back-to-back: second start in the y_ready cycle
        n0 = pulse_log.size();
        start(4'd2, 4'd3, 1'b1, 8'd6);
        repeat (WIDTH) @(posedge clk);
        #1;
        check("b2b_y_ready_cycle", int'(y_ready), 1);
        start(4'd4, 4'd4, 1'b1, 8'd16);
        wait_done();
        check("b2b_pulses", pulse_log.size() - n0, 2);
        if (pulse_log.size() - n0 == 2)
            check("b2b_spacing", pulse_log[n0+1] - pulse_log[n0], WIDTH + 1);

        // Reset aborts an in-flight operation
        start(4'd11, 4'd11, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_y_out", int'(y_out), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_y_ready", int'(y_ready), 0);
        n0 = pulse_log.size();
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_pulse", pulse_log.size(), n0);
        start(4'd5, 4'd5, 1'b1, 8'd25);
        wait_done();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
